multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS-subset datapath: walks each instruction through fetch, decode, execute, memory and write-back states, issuing per-cycle datapath enables and mux selects. Sits beside the shared instruction/data memory and the register file/ALU, replacing the single-cycle decode with a state machine. Handshakes with variable-latency memory, traps illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_control.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer: walks each instruction through fetch/decode/execute/
// memory/write-back, handshakes with variable-latency memory and traps illegal ops and timeouts.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       fetch_gate;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  // Branch resolution happens in the datapath via pc_write_cond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic mem_cause);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read   = 1'b1;
        c.fetch_gate = 1'b1;
        c.alu_src_b  = 2'b01;
        c.alu_op     = 3'b011;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b011;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b011;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 3'b010;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b100;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: c.alu_op = 3'b111;
          OP_ORI:  c.alu_op = 3'b101;
          OP_SLTI: c.alu_op = 3'b001;
          default: c.alu_op = 3'b011;
        endcase
      end
      S_I_WB: c.reg_write = 1'b1;
      S_TRAP: begin
        c.illegal_op = ~mem_cause;
        c.mem_fault  = mem_cause;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cause_q, cause_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              in_wait;
  logic              timeout_hit;
  logic              retire;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    wait_d      = '0;
    retire      = 1'b0;
    in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout_hit = (MEM_TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Counter only runs while stalled in the same wait state; any entry or handshake clears it.
    if (in_wait && !mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    ctrl_d    = decode(state_d, opcode, cause_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 1'b0;
      retired_q <= '0;
      ctrl_q    <= decode(S_FETCH, 6'd0, 1'b0);
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // IR load and PC increment in FETCH complete in the same cycle memory answers.
  assign ir_write      = ctrl_q.fetch_gate & mem_ready;
  assign pc_write      = ctrl_q.pc_write | (ctrl_q.fetch_gate & mem_ready);
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign illegal_op    = ctrl_q.illegal_op;
  assign mem_fault     = ctrl_q.mem_fault;
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/controls/retired count
// go through a scoreboard queue and are checked with immediate assertions.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3;
  localparam logic [3:0] MEM_WB = 4'd4, MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8, JUMP = 4'd9, I_EXEC = 4'd10, I_WB = 4'd11, TRAP = 4'd12;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             illegal_op, mem_fault;
  logic [CNT_W-1:0] retired;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_fault(mem_fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] obs_ctrl;
  assign obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op, mem_fault};

  typedef struct {
    string            tag;
    logic [3:0]       st;
    logic [18:0]      ctrl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t             sb[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_ret  = '0;

  // Control vector expected in each state, straight from the state/control table.
  function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                           input logic [5:0] op, input logic tk);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rwr = 0, srca = 0, ill = 0, mf = 0;
    logic [1:0] srcb = 2'b00, psrc = 2'b00;
    logic [2:0] aop = 3'b000;
    case (st)
      FETCH:    begin mrd = 1; srcb = 2'b01; aop = 3'b011; irw = rdy; pcw = rdy; end
      DECODE:   begin srcb = 2'b11; aop = 3'b011; end
      MEM_ADDR: begin srca = 1; srcb = 2'b10; aop = 3'b011; end
      MEM_RD:   begin mrd = 1; iord = 1; end
      MEM_WB:   begin rwr = 1; m2r = 1; end
      MEM_WR:   begin mwr = 1; iord = 1; end
      R_EXEC:   begin srca = 1; srcb = 2'b00; aop = 3'b010; end
      R_WB:     begin rwr = 1; rdst = 1; end
      BRANCH:   begin srca = 1; aop = 3'b100; pcwc = 1; psrc = 2'b01; end
      JUMP:     begin pcw = 1; psrc = 2'b10; end
      I_EXEC: begin
        srca = 1; srcb = 2'b10;
        case (op)
          6'b001000: aop = 3'b011;
          6'b001100: aop = 3'b111;
          6'b001101: aop = 3'b101;
          6'b001010: aop = 3'b001;
          default:   aop = 3'bxxx;
        endcase
      end
      I_WB:     rwr = 1;
      TRAP:     begin ill = !tk; mf = tk; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, psrc, ill, mf};
  endfunction

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    n_assert++;
    assert (state === e.st) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
    end
    n_assert++;
    assert (obs_ctrl === e.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs_ctrl, e.ctrl);
    end
    n_assert++;
    assert (retired === e.ret) else begin
      n_fail++;
      $error("FAIL %s retired: observed %0d expected %0d", e.tag, retired, e.ret);
    end
  endtask

  // One cycle: drive inputs, record expectation, sample after settling, advance the clock.
  task automatic step(input logic rdy, input logic [5:0] op, input logic [3:0] st,
                      input logic tk, input string tag);
    exp_t e;
    mem_ready = rdy;
    opcode    = op;
    e.tag  = tag;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy, op, tk);
    e.ret  = exp_ret;
    sb.push_back(e);
    #1;
    check_front();
    $display("step %-8s state=%0d ctrl=%b retired=%0d", tag, state, obs_ctrl, retired);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input string tag);
    step(1'b1, op, FETCH, 1'b0, tag);
    step(1'b1, op, DECODE, 1'b0, tag);
  endtask

  logic [5:0] iops [4];

  initial begin
    iops = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b0;
    #1 rst_n = 1'b0;
    step(1'b1, 6'd0, FETCH, 1'b0, "reset");
    rst_n = 1'b1;

    fetch_decode(6'b000000, "rtype");
    step(1'b1, 6'b000000, R_EXEC, 1'b0, "rtype");
    step(1'b1, 6'b000000, R_WB, 1'b0, "rtype");
    exp_ret++;

    fetch_decode(6'b100011, "lw");
    step(1'b1, 6'b100011, MEM_ADDR, 1'b0, "lw");
    for (int i = 0; i < 3; i++) step(1'b0, 6'b100011, MEM_RD, 1'b0, "lw_wait");
    step(1'b1, 6'b100011, MEM_RD, 1'b0, "lw");
    step(1'b1, 6'b100011, MEM_WB, 1'b0, "lw");
    exp_ret++;

    zero = 1'b1;
    fetch_decode(6'b000100, "beq");
    step(1'b1, 6'b000100, BRANCH, 1'b0, "beq");
    exp_ret++;
    zero = 1'b0;

    fetch_decode(6'b111111, "illegal");
    step(1'b1, 6'b111111, TRAP, 1'b0, "illegal");

    for (int k = 0; k < 4; k++) begin
      fetch_decode(iops[k], "itype");
      step(1'b1, iops[k], I_EXEC, 1'b0, "itype");
      step(1'b1, iops[k], I_WB, 1'b0, "itype");
      exp_ret++;
    end

    fetch_decode(6'b101011, "sw");
    step(1'b1, 6'b101011, MEM_ADDR, 1'b0, "sw");
    step(1'b1, 6'b101011, MEM_WR, 1'b0, "sw");
    exp_ret++;

    fetch_decode(6'b101011, "sw_to");
    step(1'b1, 6'b101011, MEM_ADDR, 1'b0, "sw_to");
    for (int i = 0; i < 16; i++) step(1'b0, 6'b101011, MEM_WR, 1'b0, "sw_to");
    step(1'b0, 6'b101011, TRAP, 1'b1, "sw_to");

    for (int i = 0; i < 16; i++) step(1'b0, 6'd0, FETCH, 1'b0, "fetch_to");
    step(1'b0, 6'd0, TRAP, 1'b1, "fetch_to");

    fetch_decode(6'b100011, "lw_rst");
    step(1'b1, 6'b100011, MEM_ADDR, 1'b0, "lw_rst");
    step(1'b0, 6'b100011, MEM_RD, 1'b0, "lw_rst");
    rst_n = 1'b0;
    exp_ret = '0;
    step(1'b1, 6'd0, FETCH, 1'b0, "mid_rst");
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      fetch_decode(6'b000010, "jump");
      step(1'b1, 6'b000010, JUMP, 1'b0, "jump");
      exp_ret++;
    end
    step(1'b1, 6'd0, FETCH, 1'b0, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
